// File: rtl/debug_unit_receive_if.sv
// Command/bus bundle between the debug receive front end and its neighbours.
// The master side drives the UART, halt and transmit-done inputs.
// The slave side (debug_unit_receive) drives memory writes and core controls.
interface debug_unit_receive_if #(
  parameter int N_BITS_INSTR = 32,
  parameter int N_BITS_UART  = 8,
  parameter int N_BITS_ADDR  = 8,
  parameter int NB_STATE     = 3
);
  logic [N_BITS_UART-1:0]  i_uart_rx_data;
  logic                    i_uart_rx_done;
  logic                    i_halt;
  logic                    i_tx_done;
  logic                    o_instr_wr_en;
  logic [N_BITS_ADDR-1:0]  o_instr_addr;
  logic [N_BITS_INSTR-1:0] o_instr_data;
  logic                    o_program_loaded;
  logic                    o_execution_mode;
  logic                    o_step;
  logic                    o_run;
  logic [NB_STATE-1:0]     o_state;

  modport master (
    output i_uart_rx_data, i_uart_rx_done, i_halt, i_tx_done,
    input  o_instr_wr_en, o_instr_addr, o_instr_data, o_program_loaded,
           o_execution_mode, o_step, o_run, o_state
  );

  modport slave (
    input  i_uart_rx_data, i_uart_rx_done, i_halt, i_tx_done,
    output o_instr_wr_en, o_instr_addr, o_instr_data, o_program_loaded,
           o_execution_mode, o_step, o_run, o_state
  );
endinterface

// File: rtl/debug_unit_receive.sv
// Debug unit command front end: decodes UART command bytes, loads programs
// into instruction memory word by word (LSB byte first) and drives the
// continuous-run / single-step controls of the core.
module debug_unit_receive #(
  parameter int N_BITS_INSTR = 32,
  parameter int N_BITS_UART  = 8,
  parameter int N_BITS_ADDR  = 8,
  parameter int NB_STATE     = 3
) (
  input logic                 i_clock,
  input logic                 i_reset,
  debug_unit_receive_if.slave bus
);

  localparam int BYTES_PER_WORD = N_BITS_INSTR / N_BITS_UART;
  localparam int BW             = $clog2(BYTES_PER_WORD);

  localparam logic [N_BITS_UART-1:0] CMD_LOAD = 8'h4C;
  localparam logic [N_BITS_UART-1:0] CMD_CONT = 8'h43;
  localparam logic [N_BITS_UART-1:0] CMD_STEP = 8'h53;
  localparam logic [N_BITS_UART-1:0] CMD_NEXT = 8'h4E;
  localparam logic [N_BITS_UART-1:0] CMD_EXIT = 8'h45;

  typedef enum logic [NB_STATE-1:0] {
    IDLE       = NB_STATE'(0),
    LOAD_COUNT = NB_STATE'(1),
    LOAD_BYTES = NB_STATE'(2),
    WRITE      = NB_STATE'(3),
    RUN_CONT   = NB_STATE'(4),
    STEP_WAIT  = NB_STATE'(5),
    STEP_BUSY  = NB_STATE'(6)
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           byte_cnt_q, byte_cnt_d;
  logic [N_BITS_INSTR-1:0] shift_q, shift_d;
  logic [N_BITS_ADDR-1:0]  count_q, count_d;
  logic [N_BITS_ADDR-1:0]  index_q, index_d;
  logic [N_BITS_ADDR-1:0]  addr_q, addr_d;
  logic [N_BITS_INSTR-1:0] data_q, data_d;
  logic                    loaded_q, loaded_d;
  logic                    mode_q, mode_d;
  logic                    step_q, step_d;
  logic                    halt_seen_q, halt_seen_d;

  logic                    rx_valid;
  logic [N_BITS_UART-1:0]  rx_byte;
  logic                    last_byte;
  logic                    last_word;
  logic                    halt_any;
  logic [N_BITS_INSTR-1:0] shift_ins;

  assign rx_valid  = bus.i_uart_rx_done;
  assign rx_byte   = bus.i_uart_rx_data;
  assign last_byte = (byte_cnt_q == BW'(BYTES_PER_WORD - 1));
  assign last_word = (index_q == count_q - N_BITS_ADDR'(1));
  assign halt_any  = halt_seen_q | bus.i_halt;

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    shift_ins = shift_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (byte_cnt_q == BW'(k)) shift_ins[k*N_BITS_UART +: N_BITS_UART] = rx_byte;
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode from command bytes, halt and transmit-done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_byte == CMD_LOAD)                  state_d = LOAD_COUNT;
        else if (rx_byte == CMD_CONT && loaded_q) state_d = RUN_CONT;
        else if (rx_byte == CMD_STEP && loaded_q) state_d = STEP_WAIT;
      end
      LOAD_COUNT: if (rx_valid) state_d = (rx_byte == '0) ? IDLE : LOAD_BYTES;
      LOAD_BYTES: if (rx_valid && last_byte) state_d = WRITE;
      WRITE:      state_d = last_word ? IDLE : LOAD_BYTES;
      RUN_CONT:   if (bus.i_halt) state_d = IDLE;
      STEP_WAIT: if (rx_valid) begin
        if (rx_byte == CMD_NEXT)      state_d = STEP_BUSY;
        else if (rx_byte == CMD_EXIT) state_d = IDLE;
      end
      STEP_BUSY:  if (bus.i_tx_done) state_d = halt_any ? IDLE : STEP_WAIT;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath updates: byte assembly, word indexing, mode, step and halt latch.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    count_d     = count_q;
    index_d     = index_q;
    addr_d      = addr_q;
    data_d      = data_q;
    loaded_d    = loaded_q;
    mode_d      = mode_q;
    step_d      = 1'b0;
    halt_seen_d = halt_seen_q;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_byte == CMD_LOAD)                  loaded_d = 1'b0;
        else if (rx_byte == CMD_CONT && loaded_q) mode_d   = 1'b0;
        else if (rx_byte == CMD_STEP && loaded_q) mode_d   = 1'b1;
      end
      LOAD_COUNT: if (rx_valid && rx_byte != '0) begin
        count_d    = N_BITS_ADDR'(rx_byte);
        index_d    = '0;
        byte_cnt_d = '0;
      end
      LOAD_BYTES: if (rx_valid) begin
        shift_d    = shift_ins;
        byte_cnt_d = byte_cnt_q + BW'(1);
        if (last_byte) begin
          data_d = shift_ins;
          addr_d = index_q;
        end
      end
      WRITE: begin
        if (last_word) begin
          loaded_d = 1'b1;
        end else begin
          index_d = index_q + N_BITS_ADDR'(1);
          // A byte landing in the write cycle starts the next word (lane 0).
          if (rx_valid) begin
            shift_d    = shift_ins;
            byte_cnt_d = BW'(1);
          end
        end
      end
      STEP_WAIT: if (rx_valid) begin
        if (rx_byte == CMD_NEXT) begin
          step_d      = 1'b1;
          halt_seen_d = 1'b0;
        end else if (rx_byte == CMD_EXIT) begin
          mode_d = 1'b0;
        end
      end
      STEP_BUSY: begin
        halt_seen_d = halt_any;
        if (bus.i_tx_done) begin
          halt_seen_d = 1'b0;
          if (halt_any) mode_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      index_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      loaded_q    <= 1'b0;
      mode_q      <= 1'b0;
      step_q      <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      index_q     <= index_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      loaded_q    <= loaded_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Outputs: write strobe and run follow the state; the rest are registers.
  always_comb begin
    bus.o_instr_wr_en    = (state_q == WRITE);
    bus.o_run            = (state_q == RUN_CONT);
    bus.o_state          = state_q;
    bus.o_instr_addr     = addr_q;
    bus.o_instr_data     = data_q;
    bus.o_program_loaded = loaded_q;
    bus.o_execution_mode = mode_q;
    bus.o_step           = step_q;
  end

endmodule

// File: tb/tb_debug_unit_receive.sv
// Self-checking bench for debug_unit_receive: directed scenarios with literal
// expectations, then randomized traffic compared every cycle with a
// behavioural command-interpreter model.
`timescale 1ns/1ps
module tb_debug_unit_receive;

  localparam int S_IDLE = 0, S_LCNT = 1, S_LBYT = 2, S_WR = 3,
                 S_RUN = 4, S_SWAIT = 5, S_SBUSY = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_unit_receive_if bus ();

  debug_unit_receive dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state   = S_IDLE;
  bit          m_loaded  = 1'b0;
  bit          m_mode    = 1'b0;
  bit          m_step    = 1'b0;
  bit          m_halted  = 1'b0;
  int          m_nwords  = 0;
  int          m_widx    = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr    = '0;
  logic [31:0] m_data    = '0;

  always @(posedge clk) begin
    logic [7:0] b;
    bit         got;
    b        = bus.i_uart_rx_data;
    got      = bus.i_uart_rx_done;
    m_step   = 1'b0;
    if (rst) begin
      m_state = S_IDLE; m_loaded = 0; m_mode = 0; m_halted = 0;
      m_nwords = 0; m_widx = 0; m_bytes.delete(); m_addr = '0; m_data = '0;
    end else begin
      case (m_state)
        S_IDLE: if (got) begin
          if (b == 8'h4C) begin m_state = S_LCNT; m_loaded = 0; end
          else if (b == 8'h43 && m_loaded) begin m_state = S_RUN; m_mode = 0; end
          else if (b == 8'h53 && m_loaded) begin m_state = S_SWAIT; m_mode = 1; end
        end
        S_LCNT: if (got) begin
          if (b == 0) m_state = S_IDLE;
          else begin m_nwords = b; m_widx = 0; m_bytes.delete(); m_state = S_LBYT; end
        end
        S_LBYT: if (got) begin
          m_bytes.push_back(b);
          if (m_bytes.size() == 4) begin
            logic [31:0] w;
            w = 0;
            foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (8 * i));
            m_data = w;
            m_addr = 32'(m_widx);
            m_bytes.delete();
            m_state = S_WR;
          end
        end
        S_WR: begin
          if (m_widx == m_nwords - 1) begin m_loaded = 1; m_state = S_IDLE; end
          else begin
            m_widx++;
            m_state = S_LBYT;
            if (got) m_bytes.push_back(b);
          end
        end
        S_RUN: if (bus.i_halt) m_state = S_IDLE;
        S_SWAIT: if (got) begin
          if (b == 8'h4E) begin m_state = S_SBUSY; m_step = 1; m_halted = 0; end
          else if (b == 8'h45) begin m_state = S_IDLE; m_mode = 0; end
        end
        S_SBUSY: begin
          if (bus.i_halt) m_halted = 1;
          if (bus.i_tx_done) begin
            if (m_halted) begin m_mode = 0; m_state = S_IDLE; end
            else m_state = S_SWAIT;
            m_halted = 0;
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare + DUT activity capture ----------------
  logic [31:0] dut_mem [256];
  int          wr_count   = 0;
  int          step_count = 0;

  always @(negedge clk) begin
    if (started) begin
      check("state",  64'(bus.o_state),          64'(m_state));
      check("loaded", 64'(bus.o_program_loaded), 64'(m_loaded));
      check("mode",   64'(bus.o_execution_mode), 64'(m_mode));
      check("run",    64'(bus.o_run),            64'(m_state == S_RUN));
      check("step",   64'(bus.o_step),           64'(m_step));
      check("wr_en",  64'(bus.o_instr_wr_en),    64'(m_state == S_WR));
      if (m_state == S_WR) begin
        check("wr_addr", 64'(bus.o_instr_addr), 64'(m_addr));
        check("wr_data", 64'(bus.o_instr_data), 64'(m_data));
      end
      if (bus.o_run && bus.o_execution_mode) check("run_in_step_mode", 64'(1), 64'(0));
    end
    if (bus.o_instr_wr_en === 1'b1) begin
      dut_mem[bus.o_instr_addr] = bus.o_instr_data;
      wr_count++;
    end
    if (bus.o_step === 1'b1) step_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.i_uart_rx_data = b;
    bus.i_uart_rx_done = 1'b1;
    tick(1);
    bus.i_uart_rx_done = 1'b0;
    tick(gap);
  endtask

  task automatic pulse_halt();
    bus.i_halt = 1'b1; tick(1); bus.i_halt = 1'b0;
  endtask

  task automatic pulse_tx();
    bus.i_tx_done = 1'b1; tick(1); bus.i_tx_done = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] cmds [5];
    cmds = '{8'h4C, 8'h43, 8'h53, 8'h4E, 8'h45};
    if ($urandom_range(0, 9) < 5) return cmds[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int w0, s0;
    logic [7:0] seq_load [10];
    seq_load = '{8'h4C, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bus.i_uart_rx_data = '0;
    bus.i_uart_rx_done = 1'b0;
    bus.i_halt         = 1'b0;
    bus.i_tx_done      = 1'b0;
    rst = 1'b1;
    tick(2);
    started = 1'b1;
    rst = 1'b0;

    // Reset state.
    check("rst_state",  64'(bus.o_state), 64'(0));
    check("rst_loaded", 64'(bus.o_program_loaded), 64'(0));
    check("rst_run",    64'(bus.o_run), 64'(0));

    // Two-word load, LSB byte first.
    w0 = wr_count;
    foreach (seq_load[i]) send(seq_load[i], 1);
    tick(1);
    check("load_wr_pulses", 64'(wr_count - w0), 64'(2));
    check("load_word0",     64'(dut_mem[0]), 64'h12345678);
    check("load_word1",     64'(dut_mem[1]), 64'hDEADBEEF);
    check("load_done",      64'(bus.o_program_loaded), 64'(1));
    check("load_idle",      64'(bus.o_state), 64'(S_IDLE));

    // Zero-count load leaves nothing loaded; 'C' then does nothing.
    w0 = wr_count;
    send(8'h4C, 1); send(8'h00, 1);
    check("zero_no_write", 64'(wr_count - w0), 64'(0));
    check("zero_loaded",   64'(bus.o_program_loaded), 64'(0));
    check("zero_idle",     64'(bus.o_state), 64'(S_IDLE));
    send(8'h43, 1);
    check("zero_no_run",   64'(bus.o_run), 64'(0));

    // Continuous run after a one-word load, stopped by halt.
    send(8'h4C, 1); send(8'h01, 1);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 2);
    check("cont_word", 64'(dut_mem[0]), 64'h44332211);
    send(8'h43, 1);
    check("cont_run",  64'(bus.o_run), 64'(1));
    check("cont_mode", 64'(bus.o_execution_mode), 64'(0));
    pulse_halt();
    check("cont_halt_run",   64'(bus.o_run), 64'(0));
    check("cont_halt_state", 64'(bus.o_state), 64'(S_IDLE));

    // Step mode.
    send(8'h53, 1);
    check("step_mode",  64'(bus.o_execution_mode), 64'(1));
    check("step_state", 64'(bus.o_state), 64'(S_SWAIT));
    s0 = step_count;
    send(8'h4E, 1);
    check("step_one_pulse", 64'(step_count - s0), 64'(1));
    check("step_busy",      64'(bus.o_state), 64'(S_SBUSY));
    send(8'h4E, 1);
    check("step_no_extra",  64'(step_count - s0), 64'(1));
    pulse_tx();
    check("step_back_wait", 64'(bus.o_state), 64'(S_SWAIT));
    send(8'h4E, 1);
    check("step_second",    64'(step_count - s0), 64'(2));
    pulse_tx();
    send(8'h45, 1);
    check("step_exit_state", 64'(bus.o_state), 64'(S_IDLE));
    check("step_exit_mode",  64'(bus.o_execution_mode), 64'(0));

    // Halt while a step is in flight ends step mode.
    send(8'h53, 1); send(8'h4E, 1);
    pulse_halt(); tick(1); pulse_tx(); tick(1);
    check("halt_step_state", 64'(bus.o_state), 64'(S_IDLE));
    check("halt_step_mode",  64'(bus.o_execution_mode), 64'(0));

    // Reset in the middle of a load.
    send(8'h4C, 1); send(8'h03, 1); send(8'hAA, 1); send(8'hBB, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("mid_rst_state",  64'(bus.o_state), 64'(0));
    check("mid_rst_loaded", 64'(bus.o_program_loaded), 64'(0));
    check("mid_rst_wr",     64'(bus.o_instr_wr_en), 64'(0));
    check("mid_rst_addr",   64'(bus.o_instr_addr), 64'(0));
    check("mid_rst_data",   64'(bus.o_instr_data), 64'(0));
    check("mid_rst_mode",   64'(bus.o_execution_mode), 64'(0));
    w0 = wr_count;
    send(8'h4C, 1); send(8'h01, 1);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 2);
    check("fresh_wr_count", 64'(wr_count - w0), 64'(1));
    check("fresh_word0",    64'(dut_mem[0]), 64'h04030201);
    check("fresh_loaded",   64'(bus.o_program_loaded), 64'(1));

    // Randomized traffic: short structured loads mixed with free-running noise.
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(1, 3);
      send(8'h4C, $urandom_range(0, 1));
      send(8'(n), $urandom_range(0, 1));
      for (int j = 0; j < 4 * n; j++) send(8'($urandom), $urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        rst                = ($urandom_range(0, 599) == 0);
        bus.i_uart_rx_done = ($urandom_range(0, 2) == 0);
        bus.i_uart_rx_data = pick_byte();
        bus.i_halt         = ($urandom_range(0, 11) == 0);
        bus.i_tx_done      = ($urandom_range(0, 5) == 0);
        tick(1);
      end
      rst                = 1'b0;
      bus.i_uart_rx_done = 1'b0;
      bus.i_halt         = 1'b0;
      bus.i_tx_done      = 1'b0;
      tick(1);
    end

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_unit_receive.md
Name: debug_unit_receive

Overview:
Command front end of the debug unit. It consumes bytes from the UART receiver, loads programs into instruction memory, and selects continuous or step-by-step execution. It issues the mode, step and run controls to the MIPS core and to the debug transmit stage. It waits on the transmit stage's done pulse before accepting the next step.

Parameters:
N_BITS_INSTR, 32, instruction/word width
N_BITS_UART, 8, UART byte width
N_BITS_ADDR, 8, instruction memory word-address width (max 255 words per load)
NB_STATE, 3, state encoding width

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, synchronous, active-high
i_uart_rx_data  in  N_BITS_UART  received byte, valid when i_uart_rx_done=1
i_uart_rx_done  in  1  one-cycle pulse per received byte
i_halt  in  1  core reached HALT (level or pulse)
i_tx_done  in  1  one-cycle pulse from debug transmit: full dump sent
o_instr_wr_en  out  1  instruction memory write strobe
o_instr_addr  out  N_BITS_ADDR  word address of write
o_instr_data  out  N_BITS_INSTR  word to write
o_program_loaded  out  1  a complete program is in memory
o_execution_mode  out  1  0=continuous, 1=step
o_step  out  1  one-cycle step pulse
o_run  out  1  core clock-enable in continuous mode
o_state  out  NB_STATE  current state (debug)

Behaviour:
- Reset (synchronous, i_reset=1 at posedge): state=IDLE; all outputs 0; byte counter, word counter, shift register and word count cleared. Reset mid-load aborts the load and clears o_program_loaded.
- A byte is consumed only on a cycle with i_uart_rx_done=1. Bytes arriving in states that do not consume them are dropped.
- Commands: 0x4C 'L' load; 0x43 'C' continuous; 0x53 'S' step mode; 0x4E 'N' next step; 0x45 'E' exit step mode.
- States: IDLE=0, LOAD_COUNT=1, LOAD_BYTES=2, WRITE=3, RUN_CONT=4, STEP_WAIT=5, STEP_BUSY=6.
- IDLE:
  - 'L' -> LOAD_COUNT; clear o_program_loaded.
  - 'C' with o_program_loaded=1 -> RUN_CONT; mode=0, o_run=1 from the next cycle.
  - 'S' with o_program_loaded=1 -> STEP_WAIT; mode=1.
  - 'C'/'S' without a loaded program, or any other byte: ignored.
- LOAD_COUNT: the next byte is the word count N.
  - N=0 -> IDLE, o_program_loaded stays 0.
  - Otherwise store N, clear the word index -> LOAD_BYTES.
- LOAD_BYTES: each byte goes into word[8*k +: 8], k=0..3, LSB byte first (same order the transmit stage uses). After the 4th byte -> WRITE.
- WRITE: exactly one cycle.
  - o_instr_wr_en=1, o_instr_addr=word index, o_instr_data=assembled word. Addr/data are held until the next write.
  - If index==N-1 -> IDLE with o_program_loaded=1; otherwise index+1 -> LOAD_BYTES.
  - A byte arriving during WRITE is not lost: it is captured as byte 0 of the next word.
- RUN_CONT: o_run=1; all bytes ignored.
  - When i_halt is seen: o_run=0 the next cycle, state -> IDLE.
  - The transmit stage triggers the dump from i_halt itself.
- STEP_WAIT:
  - 'N' -> o_step=1 for exactly one cycle, then STEP_BUSY.
  - 'E' -> mode=0 -> IDLE.
  - Others ignored.
- STEP_BUSY: bytes ignored; waits for i_tx_done.
  - On i_tx_done: if i_halt was latched since step issue -> mode=0, IDLE; else -> STEP_WAIT.
  - i_halt latch clears on leaving STEP_BUSY.
- o_step is never asserted outside the STEP_WAIT->STEP_BUSY transition. o_run is never 1 while mode=1.
- i_halt=1 in IDLE/STEP_WAIT has no effect.

Test Plan:
- Load: bytes 4C,02,78,56,34,12,EF,BE,AD,DE -> two single-cycle wr_en pulses: addr0=0x12345678, addr1=0xDEADBEEF; o_program_loaded=1 after the second write.
- Zero-count load: 4C,00 -> no wr_en, state IDLE, o_program_loaded=0. Then 43 -> o_run stays 0.
- Continuous: after load, 43 -> mode=0, o_run=1. Pulse i_halt -> o_run=0 next cycle, state IDLE.
- Step: after load, 53,4E -> exactly one o_step pulse, state STEP_BUSY. A second 4E before i_tx_done produces no pulse. i_tx_done -> STEP_WAIT; 4E -> pulse again; 45 -> IDLE, mode=0.
- Halt in step: 4E, i_halt=1, then i_tx_done -> IDLE, mode=0.
- Reset mid-load: 4C,03,AA,BB, then assert i_reset -> all outputs 0, IDLE. A fresh 4C,01 + 4 bytes writes addr0.
